symbol_grid_sequencer: RTL

- Upstream control stage for the per-cell symbol drawer in the 160x120 VGA display path.
- Walks a ROWS x COLS grid of cells. For each cell it first clears a CELL x CELL background square, then, if the cell's mask bit is set, enables the symbol drawer and waits for its completion flag.
- Muxes its own clear pixels and the drawer's pixel stream onto a single VGA-adapter write port.

---
 rtl/grid_pkg.sv | 25 ++
 rtl/symbol_grid_sequencer_if.sv | 27 ++
 rtl/cell_clear_counter.sv | 36 +++
 rtl/symbol_grid_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared types and widths for the symbol grid sequencer and its drawer/VGA bus.
package grid_pkg;

   localparam int unsigned X_W   = 8;
   localparam int unsigned Y_W   = 7;
   localparam int unsigned COL_W = 3;

   localparam logic [COL_W-1:0] BG_COLOUR_DEF = 3'b000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      DRAW  = 3'd2,
      NEXT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // One pixel as presented to the VGA adapter write port.
   typedef struct packed {
      logic [X_W-1:0]   x;
      logic [Y_W-1:0]   y;
      logic [COL_W-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/symbol_grid_sequencer_if.sv
// Drawer handshake plus VGA write port; master is the sequencer side.
interface symbol_grid_sequencer_if;
   import grid_pkg::*;

   logic             sym_in;
   logic [X_W-1:0]   cell_x;
   logic [Y_W-1:0]   cell_y;
   logic [X_W-1:0]   sym_x;
   logic [Y_W-1:0]   sym_y;
   logic [COL_W-1:0] sym_colour;
   logic             sym_next;
   logic [X_W-1:0]   vga_x;
   logic [Y_W-1:0]   vga_y;
   logic [COL_W-1:0] vga_colour;
   logic             plot;

   modport master (
      output sym_in, cell_x, cell_y, vga_x, vga_y, vga_colour, plot,
      input  sym_x, sym_y, sym_colour, sym_next
   );

   modport slave (
      input  sym_in, cell_x, cell_y, vga_x, vga_y, vga_colour, plot,
      output sym_x, sym_y, sym_colour, sym_next
   );

endinterface

// File: rtl/cell_clear_counter.sv
// 2-D cx/cy raster counter over a CELL x CELL square; cx is the inner loop.
module cell_clear_counter #(
   parameter int unsigned CELL = 16,
   parameter int unsigned CW   = $clog2(CELL)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] cx,
   output logic [CW-1:0] cy,
   output logic          last_c
);

   localparam logic [CW-1:0] MAX = CW'(CELL - 1);

   assign last_c = (cx == MAX) && (cy == MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cx <= '0;
         cy <= '0;
      end else if (clr) begin
         cx <= '0;
         cy <= '0;
      end else if (en) begin
         if (cx == MAX) begin
            cx <= '0;
            cy <= cy + CW'(1);
         end else begin
            cx <= cx + CW'(1);
         end
      end
   end

endmodule

// File: rtl/symbol_grid_sequencer.sv
// Walks a ROWS x COLS cell grid: clears each cell, then hands masked cells to
// the symbol drawer, muxing both pixel streams onto one VGA write port.
module symbol_grid_sequencer
   import grid_pkg::*;
#(
   parameter int unsigned      ORIGIN_X  = 16,
   parameter int unsigned      ORIGIN_Y  = 8,
   parameter int unsigned      CELL      = 16,
   parameter int unsigned      COLS      = 4,
   parameter int unsigned      ROWS      = 4,
   parameter logic [COL_W-1:0] BG_COLOUR = BG_COLOUR_DEF,
   parameter int unsigned      WD_LIMIT  = 63
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] cell_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 wd_err,
   symbol_grid_sequencer_if.master bus
);

   localparam int unsigned N_CELLS = ROWS * COLS;
   localparam int unsigned IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
   localparam int unsigned CW      = $clog2(CELL);
   localparam int unsigned WD_W    = $clog2(WD_LIMIT + 1);

   state_t               state, state_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [N_CELLS-1:0]   mask_q, mask_d;
   logic [WD_W-1:0]      wd, wd_d;
   logic [X_W-1:0]       cell_x_q, cell_x_d;
   logic [Y_W-1:0]       cell_y_q, cell_y_d;
   pixel_t               pix_q, pix_d;
   logic                 plot_q, plot_d;
   logic                 last_q, last_d;
   logic                 sym_in_q, sym_in_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 wd_err_q, wd_err_d;

   logic [CW-1:0]        cx, cy;
   logic                 cnt_en, cnt_clr, cnt_last_c;

   // Cell base coordinates; sums wrap silently at the port widths.
   function automatic logic [X_W-1:0] base_x(input logic [IDX_W-1:0] i);
      return X_W'(ORIGIN_X + (32'(i) % COLS) * CELL);
   endfunction

   function automatic logic [Y_W-1:0] base_y(input logic [IDX_W-1:0] i);
      return Y_W'(ORIGIN_Y + (32'(i) / COLS) * CELL);
   endfunction

   cell_clear_counter #(
      .CELL (CELL),
      .CW   (CW)
   ) u_clear_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (cnt_en),
      .clr     (cnt_clr),
      .cx      (cx),
      .cy      (cy),
      .last_c  (cnt_last_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         mask_q   <= '0;
         wd       <= '0;
         cell_x_q <= '0;
         cell_y_q <= '0;
         pix_q    <= '0;
         plot_q   <= 1'b0;
         last_q   <= 1'b0;
         sym_in_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wd_err_q <= 1'b0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         mask_q   <= mask_d;
         wd       <= wd_d;
         cell_x_q <= cell_x_d;
         cell_y_q <= cell_y_d;
         pix_q    <= pix_d;
         plot_q   <= plot_d;
         last_q   <= last_d;
         sym_in_q <= sym_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wd_err_q <= wd_err_d;
      end
   end

   always_comb begin
      state_d  = state;
      idx_d    = idx;
      mask_d   = mask_q;
      wd_d     = wd;
      cell_x_d = cell_x_q;
      cell_y_d = cell_y_q;
      pix_d    = pix_q;
      plot_d   = 1'b0;
      last_d   = 1'b0;
      wd_err_d = wd_err_q;
      cnt_en   = 1'b0;
      cnt_clr  = 1'b0;

      unique case (state)
         IDLE: begin
            cnt_clr = 1'b1;
            if (start) begin
               state_d  = CLEAR;
               idx_d    = '0;
               mask_d   = cell_mask;
               wd_err_d = 1'b0;
               cell_x_d = base_x('0);
               cell_y_d = base_y('0);
            end
         end
         // Pixels are registered, so CLEAR holds one extra cycle while the last one is shown.
         CLEAR: begin
            if (!last_q) begin
               cnt_en       = 1'b1;
               plot_d       = 1'b1;
               last_d       = cnt_last_c;
               pix_d.x      = cell_x_q + X_W'(cx);
               pix_d.y      = cell_y_q + Y_W'(cy);
               pix_d.colour = BG_COLOUR;
            end else begin
               wd_d    = '0;
               state_d = mask_q[idx] ? DRAW : NEXT;
            end
         end
         // Track the drawer pixel so the port holds its last value after DRAW.
         DRAW: begin
            pix_d = '{x: bus.sym_x, y: bus.sym_y, colour: bus.sym_colour};
            wd_d  = wd + WD_W'(1);
            if (bus.sym_next) begin
               state_d = NEXT;
            end else if (wd == WD_W'(WD_LIMIT - 1)) begin
               state_d  = NEXT;
               wd_err_d = 1'b1;
            end
         end
         NEXT: begin
            cnt_clr = 1'b1;
            if (idx == IDX_W'(N_CELLS - 1)) begin
               state_d = DONE;
            end else begin
               idx_d    = idx + IDX_W'(1);
               cell_x_d = base_x(idx + IDX_W'(1));
               cell_y_d = base_y(idx + IDX_W'(1));
               state_d  = CLEAR;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      sym_in_d = (state_d == DRAW);
      busy_d   = state_d inside {CLEAR, DRAW, NEXT};
      done_d   = (state_d == DONE);
   end

   assign bus.sym_in     = sym_in_q;
   assign bus.cell_x     = cell_x_q;
   assign bus.cell_y     = cell_y_q;
   assign bus.plot       = plot_q | sym_in_q;
   assign bus.vga_x      = sym_in_q ? bus.sym_x      : pix_q.x;
   assign bus.vga_y      = sym_in_q ? bus.sym_y      : pix_q.y;
   assign bus.vga_colour = sym_in_q ? bus.sym_colour : pix_q.colour;
   assign busy           = busy_q;
   assign done           = done_q;
   assign wd_err         = wd_err_q;

endmodule
